// File: rtl/boot_pkg.sv
// Shared types and default sizing for the instruction boot loader.
package boot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN
  } loader_state_t;

  // Default geometry; instances derive their own values from their parameters.
  localparam int INST_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 256;
  localparam int BYTES_PER_WORD = INST_WIDTH_DEF / 8;
  localparam int IDX_W          = $clog2(DEPTH_DEF);

  // Bit offset of byte number idx inside a big-endian word of nbytes bytes.
  function automatic int byte_shift(input int nbytes, input int idx);
    return 8 * (nbytes - 1 - idx);
  endfunction

endpackage

// File: rtl/inst_boot_loader_inst_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
module inst_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the word count in the
  // loader, which keeps this mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_boot_loader.sv
// Boot loader: streams a byte program into instruction RAM while holding the
// core in reset, then releases the core and serves instruction fetches.
module inst_boot_loader
  import boot_pkg::*;
#(
  parameter int INST_WIDTH = INST_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int RST_HOLD   = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  reload,
  input  logic [ADDR_W-1:0]     pcf,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  core_rst,
  output logic                  done,
  output logic                  err
);

  localparam int NB = INST_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = AW + 1;

  loader_state_t         state_q, state_d;
  logic [CW-1:0]         word_count_q, word_count_d;
  logic [BW-1:0]         byte_idx_q, byte_idx_d;
  logic [7:0]            hold_q, hold_d;
  logic [INST_WIDTH-1:0] word_q, word_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic [INST_WIDTH-1:0] packed_word;
  logic                  ram_we;
  logic [INST_WIDTH-1:0] ram_rdata;
  logic [ADDR_W-1:0]     fetch_word;

  assign load_ready = ~rst & ((state_q == IDLE) || (state_q == LOAD));
  assign core_rst   = rst | (state_q != RUN);
  assign done       = ~rst & (state_q == RUN);
  assign err        = err_q;
  assign accept     = load_valid & load_ready;

  // First byte of a word starts from zero so a short final word is zero-filled.
  always_comb begin
    packed_word = (byte_idx_q == '0) ? '0 : word_q;
    packed_word = packed_word
                | (INST_WIDTH'(load_byte) << byte_shift(NB, int'(byte_idx_q)));
  end

  // NOTE: every next-state signal gets its hold value first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    byte_idx_d   = byte_idx_q;
    hold_d       = hold_q;
    word_d       = word_q;
    err_d        = err_q;
    ram_we       = 1'b0;

    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          state_d = LOAD;
          word_d  = packed_word;
          if ((byte_idx_q == BW'(NB - 1)) || load_last) begin
            byte_idx_d = '0;
            if (word_count_q == CW'(DEPTH)) begin
              err_d = 1'b1;
            end else begin
              ram_we       = 1'b1;
              word_count_d = word_count_q + 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
          if (load_last) begin
            state_d = HOLD;
            hold_d  = 8'(RST_HOLD);
          end
        end
      end
      HOLD: begin
        hold_d = hold_q - 1'b1;
        if (hold_q == 8'd1) state_d = RUN;
      end
      RUN: begin
        if (reload) begin
          state_d      = IDLE;
          word_count_d = '0;
          byte_idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_count_q <= '0;
      byte_idx_q   <= '0;
      hold_q       <= '0;
      word_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      byte_idx_q   <= byte_idx_d;
      hold_q       <= hold_d;
      word_q       <= word_d;
      err_q        <= err_d;
    end
  end

  inst_ram #(
    .W    (INST_WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(word_count_q[AW-1:0]),
    .wdata_i(packed_word),
    .raddr_i(pcf[AW+1:2]),
    .rdata_o(ram_rdata)
  );

  // Word-granular bound check covers both unloaded words and pcf past DEPTH.
  assign fetch_word = pcf >> 2;
  assign inst       = (fetch_word < ADDR_W'(word_count_q)) ? ram_rdata : '0;

endmodule

// File: tb/tb_inst_boot_loader.sv
// Directed bench for inst_boot_loader: default geometry plus a DEPTH=4 instance
// sharing the same stimulus for overflow behaviour.
module tb_inst_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_last = 1'b0;
  logic        reload = 1'b0;
  logic [31:0] pcf = '0;

  logic        load_ready, core_rst, done, err;
  logic [31:0] inst;
  logic        s_load_ready, s_core_rst, s_done, s_err;
  logic [31:0] s_inst;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_boot_loader u_dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(load_ready), .reload(reload), .pcf(pcf),
    .inst(inst), .core_rst(core_rst), .done(done), .err(err)
  );

  inst_boot_loader #(.DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(s_load_ready), .reload(reload), .pcf(pcf),
    .inst(s_inst), .core_rst(s_core_rst), .done(s_done), .err(s_err)
  );

  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clk);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    #1;
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_ready: got %b expected 1 (byte %h)", load_ready, b);
    end
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[7:0],   last);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; reload = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL run_timeout: done=%b after %0d cycles, expected 1", done, n);
    end
  endtask

  task automatic expect_inst(input string name, input logic [31:0] addr,
                             input logic [31:0] exp);
    pcf = addr;
    #1;
    total++;
    if (inst !== exp) begin
      bad++;
      $display("FAIL %s: pcf=%h got %h expected %h", name, addr, inst, exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({load_ready, core_rst, done, err} !== 4'b0100) begin
      bad++;
      $display("FAIL reset_outputs: ready/crst/done/err got %b expected 0100",
               {load_ready, core_rst, done, err});
    end
    rst = 1'b0;
    #1;
    total++;
    if (load_ready !== 1'b1 || core_rst !== 1'b1) begin
      bad++;
      $display("FAIL idle_outputs: ready=%b core_rst=%b expected 1 1", load_ready, core_rst);
    end
    expect_inst("reset_fetch", 32'h0, 32'h0);
  endtask

  task automatic test_two_word();
    send_word(32'h80800190, 1'b0);
    send_word(32'h8100012C, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
      total++;
      if (core_rst !== 1'b1 || done !== 1'b0 || load_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: core_rst=%b done=%b ready=%b expected 1 0 0",
                 i, core_rst, done, load_ready);
      end
    end
    @(negedge clk);
    total++;
    if (core_rst !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL release: core_rst=%b done=%b expected 0 1", core_rst, done);
    end
    expect_inst("two_word_0", 32'h0, 32'h80800190);
    expect_inst("two_word_1", 32'h4, 32'h8100012C);
    expect_inst("two_word_2", 32'h8, 32'h0);
    expect_inst("pcf_low_bits", 32'h7, 32'h8100012C);
  endtask

  task automatic test_partial();
    do_reset();
    send_byte(8'h09, 1'b0);
    send_byte(8'h89, 1'b1);
    wait_run();
    expect_inst("partial_0", 32'h0, 32'h09890000);
    expect_inst("partial_1", 32'h4, 32'h0);
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes [8] = '{8'h80, 8'h80, 8'h01, 8'h90, 8'h81, 8'h00, 8'h01, 8'h2C};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i], i == 7);
      if (i != 7) begin
        @(negedge clk);
        load_valid = 1'b0;
      end
    end
    wait_run();
    expect_inst("gap_0", 32'h0, 32'h80800190);
    expect_inst("gap_1", 32'h4, 32'h8100012C);
    expect_inst("gap_2", 32'h8, 32'h0);
  endtask

  task automatic test_overflow();
    logic [31:0] words [6] = '{32'h01020304, 32'h11121314, 32'h21222324,
                               32'h31323334, 32'h41424344, 32'h51525354};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_word(words[i], i == 5);
      #1;
      total++;
      if (s_err !== (i >= 4)) begin
        bad++;
        $display("FAIL small_err_word%0d: got %b expected %b", i, s_err, i >= 4);
      end
    end
    wait_run();
    total++;
    if (s_done !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL overflow_flags: small_done=%b big_err=%b expected 1 0", s_done, err);
    end
    for (int i = 0; i < 4; i++) begin
      pcf = 32'(i * 4);
      #1;
      total++;
      if (s_inst !== words[i]) begin
        bad++;
        $display("FAIL small_word%0d: got %h expected %h", i, s_inst, words[i]);
      end
    end
    pcf = 32'h10;
    #1;
    total++;
    if (s_inst !== 32'h0) begin
      bad++;
      $display("FAIL small_beyond_depth: got %h expected 0", s_inst);
    end
    expect_inst("big_word4", 32'h10, 32'h41424344);
    expect_inst("big_word5", 32'h14, 32'h51525354);
  endtask

  task automatic test_reload();
    @(negedge clk);
    reload     = 1'b1;
    load_valid = 1'b1;
    load_byte  = 8'hAA;
    load_last  = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (core_rst !== 1'b1 || done !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reload_state: core_rst=%b done=%b ready=%b expected 1 0 1",
               core_rst, done, load_ready);
    end
    @(negedge clk);
    reload = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    expect_inst("reload_cleared", 32'h0, 32'h0);
    send_word(32'hDEADBEEF, 1'b1);
    wait_run();
    expect_inst("reload_old_gated", 32'h4, 32'h0);
    expect_inst("reload_new", 32'h0, 32'hDEADBEEF);
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send_byte(8'h82, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    load_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (core_rst !== 1'b1 || load_ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midload_reset: core_rst=%b ready=%b done=%b expected 1 0 0",
               core_rst, load_ready, done);
    end
    expect_inst("midload_gated", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send_word(32'h8200012C, 1'b1);
    wait_run();
    expect_inst("midload_reload", 32'h0, 32'h8200012C);
    expect_inst("midload_word1", 32'h4, 32'h0);
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_partial();
    test_backpressure();
    test_overflow();
    test_reload();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_boot_loader.md
Name: inst_boot_loader

Overview:
- Parametrised instruction-memory front end for the processor core.
- Holds the core in reset while a program is streamed in byte-by-byte over a valid/ready link, packed into instruction words and written to an internal instruction RAM.
- After the last byte it releases the core reset after a programmable delay, then serves `inst` for the core's `pcf`.
- Unloaded or out-of-range addresses return an all-zero instruction (NOP).

Parameters:
- INST_WIDTH, 32, instruction word width in bits; must be a multiple of 8.
- DEPTH, 256, instruction RAM depth in words; power of two.
- RST_HOLD, 4, cycles `core_rst` stays high after load completes (1..255).
- ADDR_W, 32, width of the `pcf` input.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  byte-stream valid.
- load_byte  in  8  program byte.
- load_last  in  1  marks the final byte of the program; qualified by load_valid.
- load_ready  out  1  block accepts a byte this cycle.
- reload  in  1  single-cycle pulse; in RUN, returns to IDLE for a new program.
- pcf  in  ADDR_W  core fetch address, byte-addressed, word-aligned.
- inst  out  INST_WIDTH  instruction at `pcf`.
- core_rst  out  1  reset to the processor core.
- done  out  1  high in RUN once `core_rst` has dropped.
- err  out  1  sticky overflow flag: program longer than DEPTH words.

Behaviour:
- Reset (rst=1):
  - State=IDLE; word_count=0; byte_idx=0; hold counter=0.
  - load_ready=0, core_rst=1, done=0, err=0.
  - RAM contents are not cleared; word_count gates reads instead.
- States and transitions:
  - IDLE: load_ready=1, core_rst=1. The first accepted byte moves to LOAD and is handled as a LOAD byte in the same cycle.
  - LOAD: load_ready=1, core_rst=1. A byte is accepted when load_valid & load_ready.
  - Byte packing is big-endian: the first byte of a word goes to [INST_WIDTH-1:INST_WIDTH-8].
  - When byte_idx reaches INST_WIDTH/8-1, the packed word is written to RAM[word_count] on that edge; word_count increments and byte_idx wraps to 0.
  - If load_last arrives on a partial word, the missing low bytes are zero-filled and the word is written.
  - Accepted load_last: go to HOLD with counter=RST_HOLD.
  - HOLD: load_ready=0, core_rst=1, counter decrements each cycle. At counter==1, go to RUN and drop core_rst on the next edge.
  - RUN: core_rst=0, done=1, load_ready=0. load_valid is ignored.
  - reload=1 in RUN: go to IDLE on the next edge. core_rst=1 and done=0 from that edge; word_count and byte_idx are cleared. reload is ignored in other states.
- Fetch: combinational read.
  - idx = pcf[log2(DEPTH)+1:2].
  - inst = RAM[idx] if pcf < word_count*4, else 0. This covers pcf beyond DEPTH and unloaded words.
  - pcf[1:0] are ignored.
  - inst is valid in all states. The core is in reset while loading, so writes during a read are don't-care.
- Overflow:
  - A word completing when word_count==DEPTH is discarded and err is set. err stays set until rst.
  - Loading continues to load_last; word_count saturates at DEPTH.
- Simultaneous events: rst dominates everything. In RUN, load_valid together with reload behaves as reload only; the byte is not accepted.
- rst mid-LOAD or mid-HOLD: back to IDLE with word_count=0; a partially loaded program is invalidated.

Decomposition:
- Package `boot_pkg`:
  - loader_state_t enum {IDLE, LOAD, HOLD, RUN}.
  - Localparams BYTES_PER_WORD = INST_WIDTH/8 and IDX_W = $clog2(DEPTH).
- Natural sub-module `inst_ram`: single write port, asynchronous read port, DEPTH x INST_WIDTH. The FSM, packer and hold counter stay in the top.

Test Plan:
- Two-word load:
  - Stimulus: rst 2 cycles; stream bytes 80 80 01 90 81 00 01 2C with load_last on the 8th byte.
  - Response: load_ready=1 throughout. After 4 cycles in HOLD, core_rst falls and done=1. pcf=0 gives inst=0x80800190; pcf=4 gives 0x8100012C; pcf=8 gives 0.
- Partial final word:
  - Stimulus: stream 09 89 with load_last.
  - Response: pcf=0 gives inst=0x09890000. word_count=1; pcf=4 gives 0.
- Backpressure and gaps:
  - Stimulus: load_valid toggles every other cycle over 8 bytes.
  - Response: same RAM contents as the two-word load. No byte is lost or duplicated.
- Overflow with DEPTH=4:
  - Stimulus: stream 6 words.
  - Response: err=1 after the 5th word completes. pcf=16 gives 0. Words 0-3 are intact and done=1 after hold.
- Reload:
  - Stimulus: in RUN, pulse reload, then load one word 0xDEADBEEF.
  - Response: core_rst=1 the cycle after reload. pcf=4 gives 0 (the old word is gated out). pcf=0 gives 0xDEADBEEF.
- Reset mid-load:
  - Stimulus: assert rst after 3 bytes.
  - Response: state IDLE, core_rst=1, word_count=0. A subsequent full load of 0x8200012C gives that value at pcf=0.
